// File: rtl/program_counter.sv
// program_counter: fetch-side PC sequencer (IDLE/RUN/DONE) with signed relative branches and a sticky wrap error.
// Latency: inputs sampled on a rising edge decide prog_ctr/state right after that edge; all outputs are registered.
// Backpressure: stall holds the PC in RUN; halt ends the program. Optional call/ret link register under PC_LINK_EN.
module program_counter #(
  parameter int           D          = 12,
  parameter logic [D-1:0] START_ADDR = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         branch,
  input  logic [D-1:0] target,
  input  logic         halt,
`ifdef PC_LINK_EN
  input  logic         call,
  input  logic         ret,
`endif
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         wrap_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [D-1:0] pc_nxt;
  logic         err_nxt;
  logic [D:0]   inc_sum;
  logic [D:0]   br_sum;
  logic         br_wrap;
`ifdef PC_LINK_EN
  logic [D-1:0] link, link_nxt;
`endif

  assign inc_sum = {1'b0, prog_ctr} + {{D{1'b0}}, 1'b1};
  assign br_sum  = {1'b0, prog_ctr} + {1'b0, target};
  // Carry out without a negative offset is overflow; no carry with a negative offset is underflow.
  assign br_wrap = br_sum[D] ^ target[D-1];

  assign running = (state == RUN);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    err_nxt   = wrap_err;
`ifdef PC_LINK_EN
    link_nxt  = link;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
          err_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt = DONE;
        end else if (!stall) begin
`ifdef PC_LINK_EN
          if (ret) begin
            pc_nxt = link;
          end else if (call) begin
            link_nxt = inc_sum[D-1:0];
            pc_nxt   = br_sum[D-1:0];
            err_nxt  = wrap_err | br_wrap;
          end else
`endif
          if (branch) begin
            pc_nxt  = br_sum[D-1:0];
            err_nxt = wrap_err | br_wrap;
          end else begin
            pc_nxt  = inc_sum[D-1:0];
            err_nxt = wrap_err | inc_sum[D];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= START_ADDR;
      wrap_err <= 1'b0;
`ifdef PC_LINK_EN
      link     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      wrap_err <= err_nxt;
`ifdef PC_LINK_EN
      link     <= link_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a driver pushes model expectations, a monitor pops and compares each cycle.
module tb_program_counter;

  localparam int D = 12;
  localparam int MODV = 1 << D;
  localparam int START = 0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic         branch = 1'b0;
  logic [D-1:0] target = '0;
  logic         halt = 1'b0;
`ifdef PC_LINK_EN
  logic         call = 1'b0;
  logic         ret = 1'b0;
`endif
  logic [D-1:0] prog_ctr;
  logic         running;
  logic         done;
  logic         wrap_err;

  program_counter #(.D(D), .START_ADDR(START[D-1:0])) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stall    (stall),
    .branch   (branch),
    .target   (target),
    .halt     (halt),
`ifdef PC_LINK_EN
    .call     (call),
    .ret      (ret),
`endif
    .prog_ctr (prog_ctr),
    .running  (running),
    .done     (done),
    .wrap_err (wrap_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    bit run;
    bit dn;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: phase 0 = idle, 1 = running, 2 = finished.
  int m_phase = 0;
  int m_pc    = START;
  bit m_err   = 1'b0;
  int m_link  = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  function automatic int to_signed(input logic [D-1:0] t);
    return (int'(t) >= MODV / 2) ? int'(t) - MODV : int'(t);
  endfunction

  task automatic jump(input logic [D-1:0] t);
    int res;
    res = m_pc + to_signed(t);
    if (res < 0 || res > MODV - 1) m_err = 1'b1;
    m_pc = ((res % MODV) + MODV) % MODV;
  endtask

  task automatic drive(input bit r, input bit s, input bit st, input bit br, input bit h,
                       input logic [D-1:0] t, input bit c = 1'b0, input bit rt = 1'b0);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; stall = st; branch = br; halt = h; target = t;
`ifdef PC_LINK_EN
    call = c; ret = rt;
`endif
    if (r) begin
      m_phase = 0; m_pc = START; m_err = 1'b0; m_link = 0;
    end else if (m_phase != 1) begin
      if (s) begin m_phase = 1; m_pc = START; m_err = 1'b0; end
    end else if (h) begin
      m_phase = 2;
    end else if (st) begin
      m_pc = m_pc;
`ifdef PC_LINK_EN
    end else if (rt) begin
      m_pc = m_link;
    end else if (c) begin
      m_link = (m_pc + 1) % MODV;
      jump(t);
`endif
    end else if (br) begin
      jump(t);
    end else begin
      if (m_pc == MODV - 1) m_err = 1'b1;
      m_pc = (m_pc + 1) % MODV;
    end
    e.pc = m_pc; e.run = (m_phase == 1); e.dn = (m_phase == 2); e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: outputs are presented every cycle; compare one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("prog_ctr", int'(prog_ctr), e.pc);
      check("running", int'(running), int'(e.run));
      check("done", int'(done), int'(e.dn));
      check("wrap_err", int'(wrap_err), int'(e.err));
    end
  end

  initial begin
    // Reset state and start sequence 0,1,2,3.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) idle_cycle();

    // Forward branch 20 -> 34, backward branch 200 -> 80.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd17);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h00E);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd166);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hF88);

    // Stall with branch holds; zero-offset branch holds; start in RUN ignored.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h005);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Restart, move to PC 5, then halt+stall+branch together.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd5);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd9);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd9);

    // Wrap: climb to 0xFFE without error, then 0xFFF, 0x000 with wrap_err.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h7FF);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h7FF);
    repeat (3) idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    // Branch underflow from 0.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);

`ifdef PC_LINK_EN
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd10);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 1'b1, 1'b0);
    repeat (2) idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
`endif

    // Asynchronous reset between edges at PC 57.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd57);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pc", int'(prog_ctr), START);
    check("async_rst_running", int'(running), 0);
    check("async_rst_wrap", int'(wrap_err), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) idle_cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, st, br, h, c, rt;
      logic [D-1:0] t;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 19) == 0);
      h  = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 9) == 0);
      rt = ($urandom_range(0, 11) == 0);
      t  = ($urandom_range(0, 1) == 0) ? D'($urandom_range(0, 4095))
                                       : D'($urandom_range(0, 15) - 8);
      drive(r, s, st, br, h, t, c, rt);
    end

    idle_cycle();
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Instruction-fetch sequencer that owns the program counter and consumes the signed branch offset produced by the branch-target controller. It sequences IDLE → RUN → DONE, advances the PC by one per instruction, and applies a sign-extended relative offset on taken branches. It also supports stall and halt, and raises a sticky wrap-error flag when the address space is overflowed. The block sits between the control decoder and the instruction ROM: `prog_ctr` drives the ROM address directly.

## Interface
- `D`, 12, PC width in bits; it equals the branch-offset width.
- `START_ADDR`, 0, address loaded on reset and on every program start.

Ports:
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: begin or restart a program. Sampled in IDLE and DONE.
- `stall` input, 1 bit: hold the PC this cycle.
- `branch` input, 1 bit: the branch is taken this cycle.
- `target` input, `D` bits: signed two's-complement relative offset.
- `halt` input, 1 bit: the current instruction ends the program.
- `prog_ctr` output, `D` bits: current instruction address.
- `running` output, 1 bit: high in RUN.
- `done` output, 1 bit: high in DONE.
- `wrap_err` output, 1 bit: sticky flag for PC overflow or underflow.

## Operation
- **States:** IDLE, RUN, DONE. Encoding is free.
- **Reset (asynchronous):**
  - state = IDLE
  - `prog_ctr` = START_ADDR
  - `running` = 0, `done` = 0, `wrap_err` = 0
- **IDLE:**
  - `start` → RUN; `prog_ctr` is reloaded with START_ADDR and `wrap_err` is cleared.
  - All other inputs are ignored.
- **RUN, per cycle, highest priority first:**
  - `halt` → DONE; `prog_ctr` holds. Halt wins even when `stall` or `branch` is also asserted.
  - `stall` → `prog_ctr` holds and the state stays RUN.
  - `branch` → `prog_ctr` ← `prog_ctr` + `target`, computed modulo 2^D.
  - otherwise → `prog_ctr` ← `prog_ctr` + 1, computed modulo 2^D.
- **Branch arithmetic:**
  - `target` is treated as signed D-bit and added in D+1 bits.
  - A branch with `target` = 0 holds the PC. This is legal and is not an error.
- **Wrap error:**
  - Set on an increment from 2^D−1 to 0.
  - Set on a branch whose true signed result is below 0 or above 2^D−1.
  - The PC still takes the wrapped value. The flag stays set until `reset` or an accepted `start`.
- **DONE:**
  - `prog_ctr` holds.
  - `start` → RUN, with `prog_ctr` = START_ADDR and `wrap_err` cleared.
  - `branch`, `halt` and `stall` are ignored.
- **`start` in RUN:** ignored.

## Timing
- All updates happen on the rising edge of `clk`. Outputs are registered, with no combinational input-to-output path.
- **Start latency:** `start` is sampled at edge N. `running` = 1 and `prog_ctr` = START_ADDR are visible after edge N.
- **PC update:** the inputs sampled at edge N decide `prog_ctr` after edge N. This is one cycle per instruction.
- **Halt:** `done` rises after the edge that samples `halt`. `running` falls on the same edge.
- **Reset mid-program:** outputs return to their reset values immediately, without waiting for a clock edge.

## Configuration
- **`PC_LINK_EN` defined:** adds the following.
  - Inputs `call` (1 bit) and `ret` (1 bit).
  - An internal D-bit link register, reset to 0.
  - RUN priority becomes halt > stall > ret > call > branch > increment.
  - `call`: link ← `prog_ctr` + 1 and `prog_ctr` ← `prog_ctr` + `target`. Wrap rules are the same as for a branch.
  - `ret`: `prog_ctr` ← link.
  - The link register is not cleared on `start`.
- **`PC_LINK_EN` undefined:** the `call` and `ret` ports and the link register do not exist, and the behaviour is exactly as described above.

## Test plan
- **Reset and start:** reset, then pulse `start`. Expect `prog_ctr` = 0 and `running` = 1, then `prog_ctr` = 1, 2, 3 on successive cycles.
- **Forward and backward branch:**
  - At PC 20, `branch` with `target` = 0x00E → PC 34.
  - At PC 200, `branch` with `target` = 0xF88 (−120) → PC 80, with `wrap_err` = 0.
- **Priority and zero offset:**
  - `halt`, `stall` and `branch` together at PC 5 → `done` = 1 and PC stays 5.
  - `stall` with `branch` → PC holds.
  - `branch` with `target` = 0 → PC holds.
- **Wrap:**
  - START_ADDR = 0xFFE: run three increments → PC sequence 0xFFE, 0xFFF, 0x000 and `wrap_err` = 1.
  - A later `start` clears `wrap_err`.
- **Reset mid-run:** assert `reset` between clock edges at PC 57. Expect PC = 0 and `running` = 0 immediately; `start` then restarts from 0.
- **PC_LINK_EN build:** `call` at PC 10 with `target` = 0x010 → PC 26. A later `ret` → PC 11.
